// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU responder: opcodes, FSM states
// and the default operand width.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice. Computes a single result bit plus the carry to be
// registered for the next bit position. Purely combinational.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic    a_bit,
  input  logic    b_bit,
  input  logic    a_prev,
  input  logic    a_next,
  input  logic    carry_in,
  input  alu_op_e op,
  output logic    r_bit,
  output logic    carry_out
);

  logic b_eff;

  // Per-op bit function; SUB reuses the adder with B inverted.
  always_comb begin
    r_bit     = 1'b0;
    carry_out = 1'b0;
    b_eff     = (op == OP_SUB) ? ~b_bit : b_bit;
    unique case (op)
      OP_ADD, OP_SUB: begin
        r_bit     = a_bit ^ b_eff ^ carry_in;
        carry_out = (a_bit & b_eff) | (a_bit & carry_in) | (b_eff & carry_in);
      end
      OP_AND: r_bit = a_bit & b_bit;
      OP_OR:  r_bit = a_bit | b_bit;
      OP_XOR: r_bit = a_bit ^ b_bit;
      OP_NOT: r_bit = ~a_bit;
      // Shift-out flag follows the current A bit; the last bit seen is A[MSB].
      OP_SHL: begin
        r_bit     = a_prev;
        carry_out = a_bit;
      end
      // Caller keeps only the first (bit 0) value as the shift-out flag.
      OP_SHR: begin
        r_bit     = a_next;
        carry_out = a_bit;
      end
      default: begin
        r_bit     = 1'b0;
        carry_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_serial_responder.sv
// Bit-serial ALU execution unit. Accepts one operation over a valid/ready
// request channel, computes the result LSB first through a single bit slice
// over WIDTH cycles, then presents result/carry/zero on a response channel.
module alu_serial_responder
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  alu_op_e          op_q, op_d;
  logic             a_prev_q, a_prev_d;
  logic             carry_q, carry_d;

  logic accept;
  logic last_bit;
  logic slice_r;
  logic slice_c;

  assign accept   = req_valid && (state_q == ST_IDLE);
  assign last_bit = (cnt_q == CNT_LAST);

  // Operand registers shift right so the current bit is always at index 0;
  // a_q[1] is therefore the next-higher A bit (zero-filled past the MSB).
  alu_bit_slice u_slice (
    .a_bit    (a_q[0]),
    .b_bit    (b_q[0]),
    .a_prev   (a_prev_q),
    .a_next   (a_q[1]),
    .carry_in (carry_q),
    .op       (op_q),
    .r_bit    (slice_r),
    .carry_out(slice_c)
  );

  // State register: control flops cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      carry_q <= carry_d;
    end
  end

  // Operand capture and shift registers; contents are don't-care until accept.
  always_ff @(posedge clk) begin
    a_q      <= a_d;
    b_q      <= b_d;
    op_q     <= op_d;
    a_prev_q <= a_prev_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req_valid)             state_d = ST_EXEC;
      ST_EXEC: if (last_bit)              state_d = ST_DONE;
      ST_DONE: if (rsp_ready)             state_d = ST_IDLE;
      default:                            state_d = ST_IDLE;
    endcase
  end

  // Datapath: capture on accept, shift one bit per EXEC cycle.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    a_prev_d = a_prev_q;
    r_d      = r_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    if (accept) begin
      a_d      = req_a;
      b_d      = req_b;
      op_d     = alu_op_e'(req_op);
      a_prev_d = 1'b0;
      carry_d  = (req_op == OP_SUB);
      cnt_d    = '0;
    end else if (state_q == ST_EXEC) begin
      a_d      = {1'b0, a_q[WIDTH-1:1]};
      b_d      = {1'b0, b_q[WIDTH-1:1]};
      a_prev_d = a_q[0];
      r_d      = {slice_r, r_q[WIDTH-1:1]};
      // SHR shift-out is A[0], captured on the first bit and then held.
      carry_d  = (op_q == OP_SHR && cnt_q != '0) ? carry_q : slice_c;
      cnt_d    = last_bit ? '0 : cnt_q + 1'b1;
    end
  end

  // Outputs decoded from state; zero flag only meaningful while responding.
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    rsp_valid  = (state_q == ST_DONE);
    busy       = (state_q != ST_IDLE);
    rsp_result = r_q;
    rsp_carry  = carry_q;
    rsp_zero   = (state_q == ST_DONE) && (r_q == '0);
  end

endmodule

// File: tb/tb_alu_serial_responder.sv
// Directed testbench for alu_serial_responder.
module tb_alu_serial_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [2:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_zero;
  logic        busy;

  int errors;
  int checks;

  alu_serial_responder dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_carry (rsp_carry),
    .rsp_zero  (rsp_zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue a request at #1 after an edge, count edges until rsp_valid,
  // then complete the handshake. Returns what was observed.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                        output logic [15:0] r, output logic c, output logic z,
                        output int lat, output logic rdy_seen);
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    rdy_seen = 1'b0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (req_ready) rdy_seen = 1'b1;
      if (rsp_valid) break;
    end
    r = rsp_result; c = rsp_carry; z = rsp_zero;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, rsp_valid, busy, rsp_carry, rsp_zero} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl got rdy/vld/busy/c/z=%b expected 10000",
               {req_ready, rsp_valid, busy, rsp_carry, rsp_zero});
    end
    checks++;
    if (rsp_result !== 16'h0000) begin
      errors++;
      $display("FAIL reset_result got %h expected 0000", rsp_result);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    logic [15:0] r; logic c, z, rs; int lat;
    run_op(16'hAAAA, 16'hFFFF, 3'b000, r, c, z, lat, rs);
    checks++;
    if (lat !== 16) begin errors++; $display("FAIL add_latency got %0d expected 16", lat); end
    checks++;
    if ({r, c, z} !== {16'hAAA9, 1'b1, 1'b0}) begin
      errors++; $display("FAIL add_result got %h c=%b z=%b expected aaa9 c=1 z=0", r, c, z);
    end
    checks++;
    if (rs !== 1'b0) begin errors++; $display("FAIL add_ready_busy got req_ready high expected low"); end
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL add_return_idle got rdy=%b vld=%b expected 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_op_sweep();
    logic [2:0]  ops [6]  = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    logic [15:0] exp_r [6] = '{16'hAAAA, 16'hFFFF, 16'h5555, 16'h5555, 16'h5554, 16'h5555};
    logic        exp_c [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] r; logic c, z, rs; int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(16'hAAAA, 16'hFFFF, ops[i], r, c, z, lat, rs);
      checks++;
      if ({r, c, z} !== {exp_r[i], exp_c[i], 1'b0}) begin
        errors++;
        $display("FAIL sweep_op%b got %h c=%b z=%b expected %h c=%b z=0",
                 ops[i], r, c, z, exp_r[i], exp_c[i]);
      end
    end
    // SHR with A[0]=1 to show the shift-out flag
    run_op(16'h8001, 16'h0000, 3'b111, r, c, z, lat, rs);
    checks++;
    if ({r, c} !== {16'h4000, 1'b1}) begin
      errors++; $display("FAIL shr_carry got %h c=%b expected 4000 c=1", r, c);
    end
  endtask

  task automatic test_sub();
    logic [15:0] r; logic c, z, rs; int lat;
    run_op(16'hAAAA, 16'hFFFF, 3'b001, r, c, z, lat, rs);
    checks++;
    if ({r, c, z} !== {16'hAAAB, 1'b0, 1'b0}) begin
      errors++; $display("FAIL sub_borrow got %h c=%b z=%b expected aaab c=0 z=0", r, c, z);
    end
    run_op(16'h0001, 16'h0001, 3'b001, r, c, z, lat, rs);
    checks++;
    if ({r, c, z} !== {16'h0000, 1'b1, 1'b1}) begin
      errors++; $display("FAIL sub_zero got %h c=%b z=%b expected 0000 c=1 z=1", r, c, z);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] hold_r; logic hold_c, hold_z; int n; logic ok;
    req_a = 16'h0003; req_b = 16'h0005; req_op = 3'b000; req_valid = 1'b1;
    @(posedge clk); #1;
    // Different request stays pending through EXEC and DONE.
    req_a = 16'h1234; req_b = 16'h00F0; req_op = 3'b011;
    n = 0;
    while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 16) begin errors++; $display("FAIL bp_latency got %0d expected 16", n); end
    hold_r = rsp_result; hold_c = rsp_carry; hold_z = rsp_zero;
    checks++;
    if ({hold_r, hold_c, hold_z} !== {16'h0008, 1'b0, 1'b0}) begin
      errors++; $display("FAIL bp_first got %h c=%b z=%b expected 0008 c=0 z=0", hold_r, hold_c, hold_z);
    end
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid || req_ready || rsp_result !== hold_r || rsp_carry !== hold_c || rsp_zero !== hold_z)
        ok = 1'b0;
    end
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("FAIL bp_hold got vld=%b rdy=%b %h expected stable 1 0 %h", rsp_valid, req_ready, rsp_result, hold_r);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if ({req_ready, rsp_valid, busy} !== 3'b100) begin
      errors++; $display("FAIL bp_handshake got rdy/vld/busy=%b expected 100", {req_ready, rsp_valid, busy});
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if ({req_ready, busy} !== 2'b01) begin
      errors++; $display("FAIL bp_pending_accept got rdy/busy=%b expected 01", {req_ready, busy});
    end
    n = 0;
    while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if ({rsp_result, rsp_carry, n} !== {16'h12F4, 1'b0, 32'd16}) begin
      errors++; $display("FAIL bp_second got %h c=%b lat=%0d expected 12f4 c=0 lat=16", rsp_result, rsp_carry, n);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_early_ready();
    int n;
    rsp_ready = 1'b1;
    req_a = 16'h0010; req_b = 16'h0001; req_op = 3'b100; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (rsp_result !== 16'h0011) begin
      errors++; $display("FAIL early_result got %h expected 0011", rsp_result);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      errors++; $display("FAIL early_ready got vld/rdy=%b expected 01", {rsp_valid, req_ready});
    end
  endtask

  task automatic test_reset_mid_exec();
    logic [15:0] r; logic c, z, rs; int lat; logic seen;
    req_a = 16'hFFFF; req_b = 16'h0001; req_op = 3'b000; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, rsp_valid, busy, rsp_carry, rsp_zero, rsp_result} !== {5'b10000, 16'h0000}) begin
      errors++; $display("FAIL rst_mid got rdy/vld/busy/c/z=%b res=%h expected 10000 0000",
                         {req_ready, rsp_valid, busy, rsp_carry, rsp_zero}, rsp_result);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (rsp_valid) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rst_discard got rsp_valid=1 expected 0"); end
    run_op(16'h0003, 16'h0005, 3'b000, r, c, z, lat, rs);
    checks++;
    if ({r, c, lat} !== {16'h0008, 1'b0, 32'd16}) begin
      errors++; $display("FAIL rst_recover got %h c=%b lat=%0d expected 0008 c=0 lat=16", r, c, lat);
    end
  endtask

  task automatic test_isolation();
    int n;
    req_a = 16'h00FF; req_b = 16'h0F0F; req_op = 3'b100; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin
      req_a = 16'($urandom); req_b = 16'($urandom); req_op = 3'($urandom);
      @(posedge clk); #1; n++;
    end
    checks++;
    if ({rsp_result, rsp_carry, rsp_zero} !== {16'h0FF0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL isolation got %h c=%b z=%b expected 0ff0 c=0 z=0", rsp_result, rsp_carry, rsp_zero);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_op_sweep();
    test_sub();
    test_back_to_back();
    test_early_ready();
    test_reset_mid_exec();
    test_isolation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
